// File: rtl/key_schedule_ctrl_if.sv
// Signal bundle for key_schedule_ctrl: key intake, expander drive, status and round-key read port.
interface key_schedule_ctrl_if;
  // Key intake is valid/ready: the key transfers on a rising edge where key_valid and key_ready
  // are both 1; key_ready never depends on key_valid, and an offer made while key_ready=0 is dropped.
  logic         key_valid;
  logic [127:0] key_data;
  logic         key_ready;
  logic         exp_load;
  logic [127:0] exp_key;
  logic [31:0]  exp_rcon;
  logic [127:0] exp_key_out;
  logic         keys_valid;
  logic         sched_done;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic [1:0]   dbg_state;

  modport master (
    output key_valid, key_data, exp_key_out, rk_rd_en, rk_rd_idx,
    input  key_ready, exp_load, exp_key, exp_rcon, keys_valid, sched_done, rk_rd_data, dbg_state
  );

  modport slave (
    input  key_valid, key_data, exp_key_out, rk_rd_en, rk_rd_idx,
    output key_ready, exp_load, exp_key, exp_rcon, keys_valid, sched_done, rk_rd_data, dbg_state
  );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule sequencer: drives key_expansion_logic and stores every round key for reads.
// Optional zeroize input is compiled in when KEY_SCHED_ZEROIZE_EN is defined.
module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input logic clk,
  input logic rst_n,
`ifdef KEY_SCHED_ZEROIZE_EN
  input logic zeroize,
`endif
  key_schedule_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    READY  = 2'd3
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_t       state, state_nxt;
  logic [127:0] key_q;
  logic [3:0]   cnt;
  logic [127:0] rk [0:NUM_ROUNDS];
  logic         keys_valid_q;
  logic         sched_done_q;
  logic [127:0] rd_data_q;
  logic [127:0] rd_sel;
  logic         key_ready_c;
  logic         exp_load_c;
  logic         accept;
  logic         last_store;
  logic         clear;
  logic [7:0]   rc;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign clear = zeroize;
`else
  assign clear = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Clearing wins over a key offer, so key_ready is withheld while clearing.
  always_comb begin
    state_nxt   = state;
    key_ready_c = 1'b0;
    exp_load_c  = 1'b0;
    case (state)
      IDLE, READY: begin
        key_ready_c = !clear;
        if (bus.key_valid && !clear) state_nxt = LOAD;
      end
      LOAD: begin
        exp_load_c = 1'b1;
        state_nxt  = EXPAND;
      end
      EXPAND:  if (cnt == LAST) state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  assign accept     = bus.key_valid && key_ready_c;
  assign last_store = (state == EXPAND) && (cnt == LAST);

  always_comb begin
    case (cnt)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q        <= '0;
      cnt          <= '0;
      keys_valid_q <= 1'b0;
      sched_done_q <= 1'b0;
    end else if (clear) begin
      key_q        <= '0;
      cnt          <= '0;
      keys_valid_q <= 1'b0;
      sched_done_q <= 1'b0;
    end else begin
      if (accept) key_q <= bus.key_data;
      cnt          <= ((state == EXPAND) && !last_store) ? cnt + 4'd1 : 4'd0;
      sched_done_q <= last_store;
      if (last_store)  keys_valid_q <= 1'b1;
      else if (accept) keys_valid_q <= 1'b0;
    end
  end

  // Expander output for round cnt is valid during the EXPAND cycle that precedes its store edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else if (state == EXPAND) begin
      for (int i = 0; i <= NUM_ROUNDS; i++)
        if (cnt == 4'(i)) rk[i] <= bus.exp_key_out;
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++)
      if (bus.rk_rd_idx == 4'(i)) rd_sel = rk[i];
  end

  // keys_valid_q is still set in the accept cycle, so a concurrent read returns old-key data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rd_data_q <= '0;
    else if (clear)        rd_data_q <= '0;
    else if (bus.rk_rd_en) rd_data_q <= keys_valid_q ? rd_sel : '0;
  end

  assign bus.key_ready  = key_ready_c;
  assign bus.exp_load   = exp_load_c;
  assign bus.exp_key    = key_q;
  assign bus.exp_rcon   = ((state == EXPAND) && (cnt != LAST)) ? {rc, 24'h0} : 32'h0;
  assign bus.keys_valid = keys_valid_q;
  assign bus.sched_done = sched_done_q;
  assign bus.rk_rd_data = rd_data_q;
  assign bus.dbg_state  = state;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl with a behavioural AES-128 expander and a byte-level schedule model.
module tb_key_schedule_ctrl;
  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic zeroize = 1'b0;
`endif

  key_schedule_ctrl_if bus();

  key_schedule_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize (zeroize),
`endif
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]   sbox [0:255];
  logic [127:0] exp_rk [0:NR];
  logic [127:0] exp_q [$];
  logic [127:0] exp_state = '0;

  // ---------------- helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] key_to_native(input logic [127:0] k);
    logic [127:0] n;
    for (int j = 0; j < 4; j++)
      n[32*j +: 32] = {k[8*(4*j) +: 8], k[8*(4*j+1) +: 8], k[8*(4*j+2) +: 8], k[8*(4*j+3) +: 8]};
    return n;
  endfunction

  function automatic logic [127:0] exp_step(input logic [127:0] s, input logic [31:0] rcon);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox[s[119:112]], sbox[s[111:104]], sbox[s[103:96]], sbox[s[127:120]]} ^ rcon;
    n0 = s[31:0] ^ t;
    n1 = s[63:32] ^ n0;
    n2 = s[95:64] ^ n1;
    n3 = s[127:96] ^ n2;
    return {n3, n2, n1, n0};
  endfunction

  // Stand-in for key_expansion_logic: load on exp_load, else advance one round with exp_rcon.
  always @(posedge clk) begin
    if (bus.exp_load) exp_state <= key_to_native(bus.exp_key);
    else              exp_state <= exp_step(exp_state, bus.exp_rcon);
  end
  assign bus.exp_key_out = exp_state;

  // FIPS-197 word expansion over bytes; rk[r] packs words 4r..4r+3 as {w3,w2,w1,w0}.
  task automatic ref_schedule(input logic [127:0] key);
    logic [7:0] w [0:4*(NR+1)-1][0:3];
    logic [7:0] t [0:3];
    logic [7:0] tmp, rcv;
    rcv = 8'h01;
    for (int k = 0; k < 16; k++) w[k/4][k%4] = key[8*k +: 8];
    for (int i = 4; i < 4*(NR+1); i++) begin
      for (int b = 0; b < 4; b++) t[b] = w[i-1][b];
      if (i % 4 == 0) begin
        tmp  = t[0];
        t[0] = sbox[t[1]] ^ rcv;
        t[1] = sbox[t[2]];
        t[2] = sbox[t[3]];
        t[3] = sbox[tmp];
        rcv  = xtime(rcv);
      end
      for (int b = 0; b < 4; b++) w[i][b] = w[i-4][b] ^ t[b];
    end
    for (int r = 0; r <= NR; r++)
      for (int j = 0; j < 4; j++)
        for (int b = 0; b < 4; b++)
          exp_rk[r][32*j + 8*(3-b) +: 8] = w[4*r+j][b];
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver / scenario tasks ----------------
  task automatic test_reset();
    bus.key_valid = 1'b0; bus.key_data = '0; bus.rk_rd_en = 1'b0; bus.rk_rd_idx = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b exp 1", bus.key_ready); end
    checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL reset_keys_valid got %b exp 0", bus.keys_valid); end
    checks++; if (bus.sched_done !== 1'b0) begin errors++; $display("FAIL reset_sched_done got %b exp 0", bus.sched_done); end
    checks++; if (bus.exp_load !== 1'b0) begin errors++; $display("FAIL reset_exp_load got %b exp 0", bus.exp_load); end
    checks++; if (bus.exp_rcon !== 32'h0) begin errors++; $display("FAIL reset_exp_rcon got %h exp 0", bus.exp_rcon); end
    checks++; if (bus.exp_key !== 128'h0) begin errors++; $display("FAIL reset_exp_key got %h exp 0", bus.exp_key); end
    checks++; if (bus.rk_rd_data !== 128'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", bus.rk_rd_data); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL idle_key_ready got %b exp 1", bus.key_ready); end
    bus.rk_rd_en = 1'b1; bus.rk_rd_idx = 4'd0;
    @(negedge clk);
    bus.rk_rd_en = 1'b0;
    checks++; if (bus.rk_rd_data !== 128'h0) begin errors++; $display("FAIL idle_read got %h exp 0", bus.rk_rd_data); end
  endtask

  // Accepts key, then checks every cycle of LOAD/EXPAND and the completion cycle.
  task automatic run_schedule(input logic [127:0] key, input bit hold_valid, input bit read5);
    logic [127:0] old5;
    logic [7:0]   rcv;
    logic [31:0]  rcon_exp;
    old5 = exp_rk[5];
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL sched_ready_before got %b exp 1", bus.key_ready); end
    bus.key_valid = 1'b1; bus.key_data = key;
    if (read5) begin bus.rk_rd_en = 1'b1; bus.rk_rd_idx = 4'd5; end
    @(negedge clk);
    ref_schedule(key);
    if (read5) begin
      checks++; if (bus.rk_rd_data !== old5) begin errors++; $display("FAIL read_during_accept got %h exp %h", bus.rk_rd_data, old5); end
      bus.rk_rd_en = 1'b0;
    end
    if (hold_valid) bus.key_data = ~key;
    else            bus.key_valid = 1'b0;
    rcv = 8'h01;
    for (int c = 0; c <= NR + 1; c++) begin
      checks++; if (bus.exp_load !== (c == 0)) begin errors++; $display("FAIL exp_load c=%0d got %b exp %b", c, bus.exp_load, c == 0); end
      checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL busy_key_ready c=%0d got %b exp 0", c, bus.key_ready); end
      checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL busy_keys_valid c=%0d got %b exp 0", c, bus.keys_valid); end
      checks++; if (bus.sched_done !== 1'b0) begin errors++; $display("FAIL busy_sched_done c=%0d got %b exp 0", c, bus.sched_done); end
      checks++; if (bus.exp_key !== key) begin errors++; $display("FAIL exp_key_hold c=%0d got %h exp %h", c, bus.exp_key, key); end
      if (c >= 1) begin
        rcon_exp = (c == NR + 1) ? 32'h0 : {rcv, 24'h0};
        checks++; if (bus.exp_rcon !== rcon_exp) begin errors++; $display("FAIL exp_rcon cnt=%0d got %h exp %h", c - 1, bus.exp_rcon, rcon_exp); end
        if (c <= NR) rcv = xtime(rcv);
      end
      @(negedge clk);
    end
    bus.key_valid = 1'b0;
    checks++; if (bus.keys_valid !== 1'b1) begin errors++; $display("FAIL done_keys_valid got %b exp 1", bus.keys_valid); end
    checks++; if (bus.sched_done !== 1'b1) begin errors++; $display("FAIL done_pulse got %b exp 1", bus.sched_done); end
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL done_key_ready got %b exp 1", bus.key_ready); end
    @(negedge clk);
    checks++; if (bus.sched_done !== 1'b0) begin errors++; $display("FAIL pulse_width got %b exp 0", bus.sched_done); end
    checks++; if (bus.keys_valid !== 1'b1) begin errors++; $display("FAIL keys_valid_hold got %b exp 1", bus.keys_valid); end
    checks++; if (bus.exp_load !== 1'b0) begin errors++; $display("FAIL no_queued_key got %b exp 0", bus.exp_load); end
  endtask

  task automatic test_fips();
    run_schedule(128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b, 1'b0, 1'b0);
    bus.rk_rd_en = 1'b1; bus.rk_rd_idx = 4'd0;
    @(negedge clk);
    checks++; if (bus.rk_rd_data !== 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516) begin errors++; $display("FAIL fips_rk0 got %h exp 09cf4f3cabf7158828aed2a62b7e1516", bus.rk_rd_data); end
    bus.rk_rd_idx = 4'd10;
    @(negedge clk);
    checks++; if (bus.rk_rd_data !== 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8) begin errors++; $display("FAIL fips_rk10 got %h exp b6630ca6e13f0cc8c9ee2589d014f9a8", bus.rk_rd_data); end
    bus.rk_rd_en = 1'b0;
  endtask

  task automatic test_reads();
    logic [3:0]   idx_list [0:12];
    logic [127:0] exp;
    for (int i = 0; i <= 10; i++) idx_list[i] = 4'(i);
    idx_list[11] = 4'd11;
    idx_list[12] = 4'd15;
    bus.rk_rd_en = 1'b1; bus.rk_rd_idx = idx_list[0];
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      exp = (int'(idx_list[i-1]) <= NR) ? exp_rk[idx_list[i-1]] : 128'h0;
      checks++; if (bus.rk_rd_data !== exp) begin errors++; $display("FAIL read_idx%0d got %h exp %h", idx_list[i-1], bus.rk_rd_data, exp); end
      if (i <= 12) bus.rk_rd_idx = idx_list[i];
    end
    bus.rk_rd_idx = 4'd3;
    @(negedge clk);
    checks++; if (bus.rk_rd_data !== exp_rk[3]) begin errors++; $display("FAIL read_idx3 got %h exp %h", bus.rk_rd_data, exp_rk[3]); end
    bus.rk_rd_en = 1'b0; bus.rk_rd_idx = 4'd9;
    repeat (2) begin
      @(negedge clk);
      checks++; if (bus.rk_rd_data !== exp_rk[3]) begin errors++; $display("FAIL read_hold got %h exp %h", bus.rk_rd_data, exp_rk[3]); end
    end
  endtask

  task automatic test_random_reads(input int n);
    logic [127:0] last, exp;
    logic [3:0]   idx;
    bit           en;
    bus.rk_rd_en = 1'b1; bus.rk_rd_idx = 4'd0;
    last = exp_rk[0];
    exp_q.push_back(last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++; if (bus.rk_rd_data !== exp) begin errors++; $display("FAIL rand_read step%0d got %h exp %h", i, bus.rk_rd_data, exp); end
      en  = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      if (en) last = (int'(idx) <= NR) ? exp_rk[idx] : 128'h0;
      exp_q.push_back(last);
      bus.rk_rd_en = en; bus.rk_rd_idx = idx;
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++; if (bus.rk_rd_data !== exp) begin errors++; $display("FAIL rand_read last got %h exp %h", bus.rk_rd_data, exp); end
    bus.rk_rd_en = 1'b0;
  endtask

  task automatic test_new_key_in_ready();
    run_schedule(rand_key(), 1'b1, 1'b1);
    test_random_reads(30);
  endtask

  task automatic test_back_to_back();
    repeat (2) begin
      run_schedule(rand_key(), 1'b0, 1'b0);
      test_random_reads(12);
    end
  endtask

  task automatic test_reset_mid_expand();
    bus.key_valid = 1'b1; bus.key_data = rand_key();
    @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (bus.exp_rcon !== 32'h10000000) begin errors++; $display("FAIL mid_rcon_cnt4 got %h exp 10000000", bus.exp_rcon); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_key_ready got %b exp 1", bus.key_ready); end
    checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_keys_valid got %b exp 0", bus.keys_valid); end
    checks++; if (bus.sched_done !== 1'b0) begin errors++; $display("FAIL mid_rst_sched_done got %b exp 0", bus.sched_done); end
    checks++; if (bus.exp_load !== 1'b0) begin errors++; $display("FAIL mid_rst_exp_load got %b exp 0", bus.exp_load); end
    checks++; if (bus.exp_rcon !== 32'h0) begin errors++; $display("FAIL mid_rst_exp_rcon got %h exp 0", bus.exp_rcon); end
    checks++; if (bus.exp_key !== 128'h0) begin errors++; $display("FAIL mid_rst_exp_key got %h exp 0", bus.exp_key); end
    checks++; if (bus.rk_rd_data !== 128'h0) begin errors++; $display("FAIL mid_rst_rd_data got %h exp 0", bus.rk_rd_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rk_rd_en = 1'b1; bus.rk_rd_idx = 4'(i);
      @(negedge clk);
      checks++; if (bus.rk_rd_data !== 128'h0) begin errors++; $display("FAIL post_rst_read idx%0d got %h exp 0", i, bus.rk_rd_data); end
    end
    bus.rk_rd_en = 1'b0;
    run_schedule(rand_key(), 1'b0, 1'b0);
    test_random_reads(8);
  endtask

`ifdef KEY_SCHED_ZEROIZE_EN
  task automatic test_zeroize();
    bus.rk_rd_en = 1'b1; bus.rk_rd_idx = 4'd2;
    @(negedge clk);
    checks++; if (bus.rk_rd_data !== exp_rk[2]) begin errors++; $display("FAIL zero_pre_read got %h exp %h", bus.rk_rd_data, exp_rk[2]); end
    bus.rk_rd_en = 1'b0;
    zeroize = 1'b1; bus.key_valid = 1'b1; bus.key_data = rand_key();
    @(negedge clk);
    zeroize = 1'b0; bus.key_valid = 1'b0;
    checks++; if (bus.keys_valid !== 1'b0) begin errors++; $display("FAIL zero_keys_valid got %b exp 0", bus.keys_valid); end
    checks++; if (bus.rk_rd_data !== 128'h0) begin errors++; $display("FAIL zero_rd_data got %h exp 0", bus.rk_rd_data); end
    checks++; if (bus.exp_key !== 128'h0) begin errors++; $display("FAIL zero_key_latch got %h exp 0", bus.exp_key); end
    checks++; if (bus.exp_load !== 1'b0) begin errors++; $display("FAIL zero_no_accept got %b exp 0", bus.exp_load); end
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL zero_idle got %b exp 1", bus.key_ready); end
    for (int i = 0; i <= NR; i++) begin
      bus.rk_rd_en = 1'b1; bus.rk_rd_idx = 4'(i);
      @(negedge clk);
      checks++; if (bus.rk_rd_data !== 128'h0) begin errors++; $display("FAIL zero_read idx%0d got %h exp 0", i, bus.rk_rd_data); end
    end
    bus.rk_rd_en = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    init_sbox();
    test_reset();
    test_fips();
    test_reads();
    test_new_key_in_ready();
    test_back_to_back();
`ifdef KEY_SCHED_ZEROIZE_EN
    test_zeroize();
`endif
    test_reset_mid_expand();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
